ecc_mem_scrub_ctrl: RTL and testbench
=====================================

Name: ecc_mem_scrub_ctrl

Overview:
- Sequences a 38-bit Hamming-protected SRAM for the RISCV datapath: encodes core writes, checks and corrects core reads, and writes corrected words back.
- Runs a background scrubber that walks the whole array. It shares the single SRAM port with the core, and the core always has priority.
- Instantiates one hamming_encoder for both write encoding and syndrome generation.
- Codeword layout: parity at indices 0,1,3,7,15,31; data bits 0..31 in the remaining indices in ascending order.

Parameters:
- ADDR_W, 8, SRAM address width.
- DEPTH, 256, number of words; the scrub pointer wraps at DEPTH-1.
- INTERVAL_W, 16, width of the scrub interval timer.
- CNT_W, 16, width of the error counters.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  block accepts the request this cycle.
- req_we  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  read response valid, 1-cycle pulse.
- rsp_rdata  out  32  corrected read data.
- rsp_err  out  2  00 clean, 01 corrected, 10 uncorrectable.
- mem_en  out  1  SRAM access enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  38  codeword written.
- mem_rdata  in  38  codeword read; valid the cycle after mem_en with !mem_we.
- scrub_en  in  1  enable background scrubbing.
- scrub_interval  in  INTERVAL_W  idle cycles between scrub reads; 0 means scrub every eligible cycle.
- corr_cnt  out  CNT_W  corrected-error count, saturating.
- uncorr_cnt  out  CNT_W  uncorrectable-error count, saturating.
- err_addr  out  ADDR_W  address of the most recent error.
- err_irq  out  1  1-cycle pulse on any uncorrectable error.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State goes to IDLE; the in-flight access is abandoned with no response.
  - All outputs return to 0: rsp_valid, rsp_rdata, rsp_err, counters, err_addr, err_irq, scrub_ptr, timer, scrub_pend.
  - mem_en is 0 in the cycle following reset.
- Memory port:
  - mem_* are combinational from state and accepted request; exactly one access per cycle.
  - mem_we=1 implies mem_en=1.
- FSM states: IDLE, CORE_RD, SCRUB_RD, WB.
- IDLE:
  - req_ready=1.
  - If req_valid: core access at req_addr in the same cycle.
    - Write: mem_we=1, mem_wdata=encode(req_wdata). Stay in IDLE, no response.
    - Read: go to CORE_RD.
  - Else if scrub_pend: scrub read at scrub_ptr, go to SCRUB_RD.
- CORE_RD and SCRUB_RD:
  - req_ready=0.
  - Decode mem_rdata:
    - Extract the 32 data bits and re-encode them.
    - syn[i] = mem_rdata[2^i-1] XOR reencoded[2^i-1].
    - syn=0: clean.
    - 1<=syn<=38: flip bit syn-1, corrected.
    - syn>38: uncorrectable.
  - CORE_RD: register rsp_valid=1, rsp_rdata, rsp_err at the next edge. Read latency is accept edge + 2 cycles.
  - Next state:
    - Corrected: WB, holding address and corrected codeword. Applies to both core and scrub reads.
    - Otherwise: IDLE.
  - Uncorrectable: no writeback; rsp_rdata = raw extracted data.
  - Scrub reads produce no rsp_valid.
- WB:
  - mem_we=1, writes the corrected codeword, req_ready=0, then IDLE.
  - A core request held during WB is accepted in the following IDLE cycle.
- Status:
  - Corrected: corr_cnt+1, saturating at all-ones.
  - Uncorrectable: uncorr_cnt+1, saturating; err_irq pulses in the registered-response cycle.
  - err_addr updates on either error class.
- Scrub timer:
  - While scrub_en=1 and scrub_pend=0, the timer counts up each cycle.
  - When timer==scrub_interval: set scrub_pend, clear the timer.
  - scrub_pend clears when the scrub read issues.
  - After a scrub read, scrub_ptr increments, wrapping DEPTH-1 -> 0.
  - scrub_en=0 clears the timer and scrub_pend; scrub_ptr is retained. An in-flight scrub completes.
- Simultaneous events:
  - req_valid together with scrub_pend: the core wins and the scrub stays pending. Sustained core traffic may starve scrubbing by design.
  - Error in the same cycle as counter saturation: the counter holds, err_addr still updates.
- Known limitation: the code is SEC only. Double errors with syn<=38 are miscorrected and reported as 01.

Test Plan:
- Reset, then write 0x00000001 to addr 5 -> mem_we=1, mem_addr=5, mem_wdata=38'h0000000007, rsp_valid stays 0.
- Read addr 5 with mem_rdata=38'h07 -> rsp_valid two cycles after accept, rsp_rdata=0x1, rsp_err=00, no WB.
- Read addr 5 with mem_rdata=38'h07^(1<<10) (syn=11) -> rsp_rdata=0x1, rsp_err=01, next cycle WB writes 38'h07 to addr 5, corr_cnt=1, err_addr=5.
- Read with bits 31 and 6 flipped (syn=39) -> rsp_err=10, no WB, uncorr_cnt=1, err_irq pulses once.
- scrub_en=1, scrub_interval=3, DEPTH=4, no core traffic, clean memory -> scrub reads at addresses 0,1,2,3,0 spaced by the interval; scrub_ptr wraps; counters stay 0.
- Core req_valid held high in the cycle scrub_pend rises -> core read accepted first and the scrub issues on the next idle cycle. Assert rst during SCRUB_RD -> no WB, no counter change, mem_en=0 the next cycle.

Source files
------------

// File: rtl/ecc_mem_scrub_ctrl.sv
// ecc_mem_scrub_ctrl: SEC Hamming front-end for a 38-bit SRAM.
// Encodes core writes, checks and corrects core reads, writes corrected
// words back, and scrubs the array in the background whenever the single
// SRAM port is not needed by the core.

// hamming_encoder: places 32 data bits around six parity bits at indices
// 0,1,3,7,15,31 and computes even parity over the usual Hamming coverage.
module hamming_encoder (
  input  logic [31:0] data,
  output logic [37:0] codeword
);

  // True when codeword index p holds a parity bit (1-based position is a power of two).
  function automatic logic is_parity(input int p);
    return (((p + 1) & p) == 0);
  endfunction

  // Data bit number stored at non-parity codeword index p.
  function automatic int data_bit_of(input int p);
    int cnt;
    cnt = 0;
    for (int q = 0; q < p; q++) begin
      if (!is_parity(q)) cnt++;
    end
    return cnt;
  endfunction

  // Coverage of parity bit k: every 1-based position with bit k set.
  function automatic logic [37:0] cover_mask(input int k);
    logic [37:0] m;
    m = '0;
    for (int q = 0; q < 38; q++) begin
      if ((((q + 1) >> k) & 1) == 1) m[q] = 1'b1;
    end
    return m;
  endfunction

  logic [37:0] placed;
  logic [5:0]  parity;

  genvar gi;
  generate
    // Data bits in ascending order, parity slots left at zero.
    for (gi = 0; gi < 38; gi++) begin : g_place
      if (is_parity(gi)) begin : g_par_slot
        assign placed[gi] = 1'b0;
      end else begin : g_dat_slot
        assign placed[gi] = data[data_bit_of(gi)];
      end
    end

    for (gi = 0; gi < 6; gi++) begin : g_parity
      assign parity[gi] = ^(placed & cover_mask(gi));
    end

    for (gi = 0; gi < 38; gi++) begin : g_out
      if (is_parity(gi)) begin : g_par_out
        assign codeword[gi] = parity[$clog2(gi + 1)];
      end else begin : g_dat_out
        assign codeword[gi] = placed[gi];
      end
    end
  endgenerate

endmodule

module ecc_mem_scrub_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int INTERVAL_W = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [37:0]           mem_wdata,
  input  logic [37:0]           mem_rdata,
  input  logic                  scrub_en,
  input  logic [INTERVAL_W-1:0] scrub_interval,
  output logic [CNT_W-1:0]      corr_cnt,
  output logic [CNT_W-1:0]      uncorr_cnt,
  output logic [ADDR_W-1:0]     err_addr,
  output logic                  err_irq
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CORE_RD  = 2'd1;
  localparam logic [1:0] SCRUB_RD = 2'd2;
  localparam logic [1:0] WB       = 2'd3;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  // Codeword index holding data bit d (inverse of the encoder placement).
  function automatic int data_slot(input int d);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 0; p < 38; p++) begin
      if (((p + 1) & p) != 0) begin
        if (cnt == d) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  logic [1:0]            state_reg, state_next;
  logic [ADDR_W-1:0]     addr_reg;
  logic [37:0]           wb_cw_reg;
  logic                  rsp_valid_reg;
  logic [31:0]           rsp_rdata_reg;
  logic [1:0]            rsp_err_reg;
  logic [CNT_W-1:0]      corr_cnt_reg;
  logic [CNT_W-1:0]      uncorr_cnt_reg;
  logic [ADDR_W-1:0]     err_addr_reg;
  logic                  err_irq_reg;
  logic [ADDR_W-1:0]     scrub_ptr_reg;
  logic [INTERVAL_W-1:0] timer_reg;
  logic                  scrub_pend_reg;

  logic        core_acc;
  logic        scrub_issue;
  logic        decoding;
  logic [31:0] rd_data;
  logic [31:0] enc_in;
  logic [37:0] enc_out;
  logic [5:0]  syn;
  logic        is_corr;
  logic        is_uncorr;
  logic [37:0] flip_mask;
  logic [37:0] corr_cw;
  logic [31:0] corr_data;

  assign core_acc    = (state_reg == IDLE) && req_valid;
  assign scrub_issue = (state_reg == IDLE) && !req_valid && scrub_pend_reg;
  assign decoding    = (state_reg == CORE_RD) || (state_reg == SCRUB_RD);

  // The one encoder serves write encoding in IDLE and re-encoding of the
  // read data while a read is being checked.
  assign enc_in = (state_reg == IDLE) ? req_wdata : rd_data;

  hamming_encoder u_enc (
    .data     (enc_in),
    .codeword (enc_out)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_extract
      assign rd_data[gi]   = mem_rdata[data_slot(gi)];
      assign corr_data[gi] = corr_cw[data_slot(gi)];
    end
    for (gi = 0; gi < 6; gi++) begin : g_syn
      assign syn[gi] = mem_rdata[(2 ** gi) - 1] ^ enc_out[(2 ** gi) - 1];
    end
  endgenerate

  // Syndrome above 38 points outside the codeword, so it cannot be a single error.
  assign is_corr   = (syn != 6'd0) && (syn <= 6'd38);
  assign is_uncorr = (syn > 6'd38);
  assign flip_mask = is_corr ? (38'd1 << (syn - 6'd1)) : 38'd0;
  assign corr_cw   = mem_rdata ^ flip_mask;

  // Next-state selection: core first, then a pending scrub; correctable reads detour through WB.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (core_acc) begin
          if (!req_we) state_next = CORE_RD;
        end else if (scrub_issue) begin
          state_next = SCRUB_RD;
        end
      end
      CORE_RD, SCRUB_RD: state_next = is_corr ? WB : IDLE;
      default:           state_next = IDLE;
    endcase
  end

  // SRAM port drive: exactly one access per cycle, write only ever with enable.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    req_ready = (state_reg == IDLE);
    if (core_acc) begin
      mem_en    = 1'b1;
      mem_we    = req_we;
      mem_addr  = req_addr;
      mem_wdata = enc_out;
    end else if (scrub_issue) begin
      mem_en   = 1'b1;
      mem_addr = scrub_ptr_reg;
    end else if (state_reg == WB) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = addr_reg;
      mem_wdata = wb_cw_reg;
    end
  end

  // FSM state, in-flight address and writeback codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wb_cw_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (core_acc) addr_reg <= req_addr;
      else if (scrub_issue) addr_reg <= scrub_ptr_reg;
      if (decoding) wb_cw_reg <= corr_cw;
    end
  end

  // Registered read response; uncorrectable reads return the raw data bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 2'b00;
    end else begin
      rsp_valid_reg <= (state_reg == CORE_RD);
      if (state_reg == CORE_RD) begin
        rsp_rdata_reg <= is_uncorr ? rd_data : corr_data;
        rsp_err_reg   <= is_uncorr ? 2'b10 : (is_corr ? 2'b01 : 2'b00);
      end
    end
  end

  // Error statistics from both core and scrub reads; counters saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_reg   <= '0;
      uncorr_cnt_reg <= '0;
      err_addr_reg   <= '0;
      err_irq_reg    <= 1'b0;
    end else begin
      err_irq_reg <= decoding && is_uncorr;
      if (decoding && is_corr && (corr_cnt_reg != '1))
        corr_cnt_reg <= corr_cnt_reg + 1'b1;
      if (decoding && is_uncorr && (uncorr_cnt_reg != '1))
        uncorr_cnt_reg <= uncorr_cnt_reg + 1'b1;
      if (decoding && (is_corr || is_uncorr))
        err_addr_reg <= addr_reg;
    end
  end

  // Scrub interval timer, pending flag and wrapping scrub pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_reg      <= '0;
      scrub_pend_reg <= 1'b0;
      scrub_ptr_reg  <= '0;
    end else begin
      if (scrub_issue)
        scrub_ptr_reg <= (scrub_ptr_reg == PTR_LAST) ? '0 : scrub_ptr_reg + 1'b1;
      if (!scrub_en) begin
        timer_reg      <= '0;
        scrub_pend_reg <= 1'b0;
      end else if (scrub_issue) begin
        scrub_pend_reg <= 1'b0;
      end else if (!scrub_pend_reg) begin
        if (timer_reg == scrub_interval) begin
          scrub_pend_reg <= 1'b1;
          timer_reg      <= '0;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_rdata  = rsp_rdata_reg;
  assign rsp_err    = rsp_err_reg;
  assign corr_cnt   = corr_cnt_reg;
  assign uncorr_cnt = uncorr_cnt_reg;
  assign err_addr   = err_addr_reg;
  assign err_irq    = err_irq_reg;

endmodule

// File: tb/tb_ecc_mem_scrub_ctrl.sv
// Scoreboard bench for ecc_mem_scrub_ctrl: the stimulus thread queues
// expected responses, SRAM writes and scrub addresses; a negedge monitor
// pops and compares whenever the DUT shows activity on its ports.
module tb_ecc_mem_scrub_ctrl;

  typedef struct { logic [31:0] data; logic [1:0] err; } rsp_t;
  typedef struct { logic [7:0] addr; logic [37:0] cw; } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [37:0] mem_wdata;
  logic [37:0] mem_rdata = '0;
  logic        scrub_en;
  logic [15:0] scrub_interval;
  logic [15:0] corr_cnt, uncorr_cnt;
  logic [7:0]  err_addr;
  logic        err_irq;

  bit   [37:0] mem [256];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [37:0] poke_data = '0;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   scrub_q[$];
  int   scrub_t[$];
  int   acc_q[$];
  int   ncyc = 0;
  int   irq_cnt = 0;
  int   total = 0;
  int   passed = 0;

  ecc_mem_scrub_ctrl #(.ADDR_W(8), .DEPTH(4), .INTERVAL_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .scrub_en(scrub_en), .scrub_interval(scrub_interval),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .err_addr(err_addr), .err_irq(err_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) ncyc <= ncyc + 1;

  // SRAM model: one-cycle read latency, plus a side door for planting errors.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
  endtask

  // Monitor: compares every response, SRAM write and scrub read against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready && !req_we) acc_q.push_back(ncyc);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 0);
        end else begin
          rsp_t e;
          int   a;
          e = rsp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
          $display("rsp cycle %0d: rdata=%08h err=%0d", ncyc, rsp_rdata, rsp_err);
          check("rsp_rdata", rsp_rdata, e.data);
          check("rsp_err", rsp_err, e.err);
          check("rsp_latency", ncyc - a, 2);
        end
      end
      if (mem_en && mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", mem_we, 0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          $display("write cycle %0d: addr=%0d cw=%010h", ncyc, mem_addr, mem_wdata);
          check("wr_addr", mem_addr, w.addr);
          check("wr_cw", mem_wdata, w.cw);
        end
      end
      if (mem_en && !mem_we && !(req_valid && req_ready)) begin
        if (scrub_q.size() == 0) begin
          check("unexpected_scrub", mem_en, 0);
        end else begin
          int s;
          s = scrub_q.pop_front();
          $display("scrub cycle %0d: addr=%0d", ncyc, mem_addr);
          check("scrub_addr", mem_addr, s);
          scrub_t.push_back(ncyc);
        end
      end
      if (!mem_en && mem_we) check("we_without_en", mem_we, 0);
      if (err_irq) irq_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [37:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    tick();
    poke_en = 1'b0;
  endtask

  // Presents one core request and holds it until accepted (bounded).
  task automatic core_req(input logic we, input logic [7:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_accept_timeout", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_scrubs(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (scrub_t.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("scrub_timeout", scrub_t.size(), n);
  endtask

  task automatic expect_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] e);
    rsp_t r;
    r.data = d; r.err = e;
    rsp_q.push_back(r);
    core_req(1'b0, a, 32'h0);
    repeat (4) tick();
  endtask

  task automatic expect_wr(input logic [7:0] a, input logic [37:0] cw);
    wr_t w;
    w.addr = a; w.cw = cw;
    wr_q.push_back(w);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s5;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    scrub_en = 1'b0; scrub_interval = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_mem_en", mem_en, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_corr_cnt", corr_cnt, 0);
    check("reset_uncorr_cnt", uncorr_cnt, 0);
    check("reset_err_addr", err_addr, 0);
    check("reset_err_irq", err_irq, 0);
    tick();

    // Encoded write of 1: parity bits 0 and 1 plus data at index 2.
    expect_wr(8'd5, 38'h0000000007);
    core_req(1'b1, 8'd5, 32'h1);
    repeat (3) tick();
    expect_read(8'd5, 32'h1, 2'b00);

    // Single data-bit error at index 10 (syndrome 11).
    poke(8'd5, 38'h0000000407);
    expect_wr(8'd5, 38'h0000000007);
    expect_read(8'd5, 32'h1, 2'b01);
    check("corr_cnt_1", corr_cnt, 1);
    check("err_addr_5", err_addr, 5);

    // All-ones data: parity bits 3 and 4 set, 0,1,2,5 clear.
    expect_wr(8'd7, 38'h3F7FFFFFF4);
    core_req(1'b1, 8'd7, 32'hFFFFFFFF);
    repeat (3) tick();
    expect_read(8'd7, 32'hFFFFFFFF, 2'b00);

    // Top index 37 flipped: syndrome 38, the largest correctable value.
    poke(8'd12, 38'h2000000000);
    expect_wr(8'd12, 38'h0);
    expect_read(8'd12, 32'h0, 2'b01);
    check("corr_cnt_2", corr_cnt, 2);
    check("err_addr_12", err_addr, 12);

    // Parity bit 0 flipped: data unaffected, still rewritten.
    poke(8'd13, 38'h0000000001);
    expect_wr(8'd13, 38'h0);
    expect_read(8'd13, 32'h0, 2'b01);
    check("corr_cnt_3", corr_cnt, 3);

    // Bits 31 and 6 flipped: syndrome 39, raw data (d0|d3) returned, no writeback.
    poke(8'd9, 38'h0080000047);
    expect_read(8'd9, 32'h9, 2'b10);
    check("uncorr_cnt_1", uncorr_cnt, 1);
    check("err_addr_9", err_addr, 9);
    check("irq_pulses_1", irq_cnt, 1);
    check("corr_cnt_hold", corr_cnt, 3);

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst2_corr_cnt", corr_cnt, 0);
    check("rst2_uncorr_cnt", uncorr_cnt, 0);
    check("rst2_err_addr", err_addr, 0);
    check("rst2_rsp_rdata", rsp_rdata, 0);
    check("rst2_rsp_err", rsp_err, 0);
    tick();

    // Background scrub over a 4-word array, interval 3 -> one read every 5 cycles.
    scrub_q.push_back(0); scrub_q.push_back(1); scrub_q.push_back(2);
    scrub_q.push_back(3); scrub_q.push_back(0);
    scrub_interval = 16'd3;
    scrub_en = 1'b1;
    wait_scrubs(5);
    for (int i = 1; i < scrub_t.size(); i++) check("scrub_gap", scrub_t[i] - scrub_t[i-1], 5);
    check("scrub_corr_cnt", corr_cnt, 0);
    check("scrub_uncorr_cnt", uncorr_cnt, 0);
    s5 = (scrub_t.size() >= 5) ? scrub_t[4] : 0;

    // Core read raised in the cycle the next scrub becomes pending: core first.
    repeat (4) @(posedge clk);
    #1;
    scrub_q.push_back(1);
    begin
      rsp_t r;
      r.data = 32'h0; r.err = 2'b00;
      rsp_q.push_back(r);
    end
    core_req(1'b0, 8'd2, 32'h0);
    wait_scrubs(6);
    if (scrub_t.size() >= 6) check("scrub_after_core", scrub_t[5] - s5, 7);

    // Reset while a correctable scrub read is in flight: no writeback, counters untouched.
    #1;
    poke(8'd2, 38'h0000000001);
    scrub_q.push_back(2);
    wait_scrubs(7);
    #1;
    rst = 1'b1;
    scrub_en = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_scrub_mem_en", mem_en, 0);
    tick();
    repeat (3) tick();
    check("rst_scrub_corr_cnt", corr_cnt, 0);
    check("rst_scrub_err_addr", err_addr, 0);
    check("rst_scrub_irq", irq_cnt, 1);

    check("rsp_q_drained", rsp_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("scrub_q_drained", scrub_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
